// File: rtl/base_afreq_up_arb_if.sv
// rtl/base_afreq_up_arb_if.sv - requester-side pair handshake and fast-side word stream
interface base_afreq_up_arb_if #(
    parameter int width = 8,
    parameter int ways  = 4
);
    localparam int idw = (ways > 1) ? $clog2(ways) : 1;

    logic [ways-1:0]       i_v;
    logic [ways-1:0]       i_r;
    logic [ways*width-1:0] i_d0;
    logic [ways*width-1:0] i_d1;
    logic                  o_v;
    logic                  o_r;
    logic [width-1:0]      o_d;
    logic [idw-1:0]        o_id;
    logic                  o_odd;

    modport master (
        output i_v, i_d0, i_d1, o_r,
        input  i_r, o_v, o_d, o_id, o_odd
    );

    modport slave (
        input  i_v, i_d0, i_d1, o_r,
        output i_r, o_v, o_d, o_id, o_odd
    );
endinterface

// File: rtl/base_afreq_up_arb.sv
// rtl/base_afreq_up_arb.sv - round-robin arbiter feeding a shared 2:1 width-to-rate up-conversion lane
module base_afreq_up_arb #(
    parameter int width = 8,
    parameter int ways  = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic               clk_lo,
    base_afreq_up_arb_if.slave bus
);
    localparam int idw = (ways > 1) ? $clog2(ways) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HALF0 = 2'd1,
        HALF1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [idw-1:0]   ptr;
    logic [idw-1:0]   ptr_nx;
    logic [idw-1:0]   grant_idx;
    logic             grant_found;
    logic             load_ok;
    logic             accept;
    logic [width-1:0] d0;
    logic [width-1:0] d1;
    logic [idw-1:0]   id;
    logic [width-1:0] sel_d0;
    logic [width-1:0] sel_d1;
    logic [ways-1:0]  i_r_c;

    // Pairs may only change hands on the last fast cycle of a slow period,
    // and only when the lane is empty or is finishing its second word.
    assign load_ok = clk_lo & ((state == IDLE) | ((state == HALF1) & bus.o_r));
    assign accept  = load_ok & grant_found;

    // Rotating priority search starting at ptr.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int off = 0; off < ways; off++) begin
            idx = (int'(ptr) + off) % ways;
            if (!grant_found && bus.i_v[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx[idw-1:0];
            end
        end
    end

    always_comb begin
        sel_d0 = bus.i_d0[int'(grant_idx)*width +: width];
        sel_d1 = bus.i_d1[int'(grant_idx)*width +: width];
        ptr_nx = (int'(grant_idx) == ways - 1) ? '0 : grant_idx + 1'b1;
    end

    always_comb begin
        i_r_c = '0;
        if (accept) begin
            i_r_c[grant_idx] = 1'b1;
        end
    end

    assign bus.i_r = i_r_c;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = HALF0;
                end
            end
            HALF0: begin
                if (bus.o_r) begin
                    state_nx = HALF1;
                end
            end
            HALF1: begin
                if (bus.o_r) begin
                    state_nx = accept ? HALF0 : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            clk_lo <= 1'b0;
        end else begin
            state  <= state_nx;
            clk_lo <= ~clk_lo;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            d0  <= '0;
            d1  <= '0;
            id  <= '0;
        end else if (accept) begin
            ptr <= ptr_nx;
            d0  <= sel_d0;
            d1  <= sel_d1;
            id  <= grant_idx;
        end
    end

    // In IDLE the data mux rests on d1 so the bus does not glitch back to d0.
    assign bus.o_v   = (state != IDLE);
    assign bus.o_d   = (state == HALF0) ? d0 : d1;
    assign bus.o_odd = (state == HALF1);
    assign bus.o_id  = id;
endmodule

// File: tb/tb_base_afreq_up_arb.sv
// tb/tb_base_afreq_up_arb.sv - scoreboard bench for the shared up-conversion arbiter
module tb_base_afreq_up_arb;
    typedef struct packed {
        logic [7:0] d0;
        logic [7:0] d1;
    } pair_t;

    typedef struct {
        logic [7:0] d;
        int         id;
        logic       odd;
    } word_t;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        int         id;
        logic       odd;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clk_lo;

    base_afreq_up_arb_if #(.width(8), .ways(4)) bus();

    base_afreq_up_arb #(.width(8), .ways(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_lo (clk_lo),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int    tests_run = 0;
    int    tests_failed = 0;
    int    cyc = 0;
    int    m_phase = 0;
    int    m_left = 0;
    int    m_ptr = 0;
    pair_t pq[4][$];
    word_t sb[$];
    obs_t  olog[$];

    task automatic model_reset();
        m_phase = 0;
        m_left  = 0;
        m_ptr   = 0;
        sb.delete();
        olog.delete();
    endtask

    task automatic step();
        int         g;
        int         idx;
        bit         lok;
        bit         ev;
        logic [3:0] exp_ir;
        word_t      w;
        for (int k = 0; k < 4; k++) begin
            bus.i_v[k]          = (pq[k].size() > 0);
            bus.i_d0[k*8 +: 8]  = (pq[k].size() > 0) ? pq[k][0].d0 : 8'h00;
            bus.i_d1[k*8 +: 8]  = (pq[k].size() > 0) ? pq[k][0].d1 : 8'h00;
        end
        #1;
        ev  = (m_left != 0);
        lok = (m_phase == 1) && (m_left == 0 || (m_left == 1 && bus.o_r));
        g = -1;
        if (lok) begin
            for (int off = 0; off < 4; off++) begin
                idx = (m_ptr + off) % 4;
                if (g < 0 && pq[idx].size() > 0) g = idx;
            end
        end
        exp_ir = (g >= 0) ? (4'b0001 << g) : 4'b0000;

        tests_run++;
        if (clk_lo !== m_phase[0]) begin
            tests_failed++;
            $display("FAIL clk_lo cyc %0d: got %0b expected %0b", cyc, clk_lo, m_phase[0]);
        end
        tests_run++;
        if (bus.o_v !== ev) begin
            tests_failed++;
            $display("FAIL o_v cyc %0d: got %0b expected %0b", cyc, bus.o_v, ev);
        end
        tests_run++;
        if (bus.i_r !== exp_ir) begin
            tests_failed++;
            $display("FAIL i_r cyc %0d: got %b expected %b", cyc, bus.i_r, exp_ir);
        end
        if (ev) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL scoreboard_empty cyc %0d: got word %h expected none", cyc, bus.o_d);
            end else begin
                w = sb[0];
                if (bus.o_d !== w.d || int'(bus.o_id) != w.id || bus.o_odd !== w.odd) begin
                    tests_failed++;
                    $display("FAIL word cyc %0d: got d=%h id=%0d odd=%0b expected d=%h id=%0d odd=%0b",
                             cyc, bus.o_d, bus.o_id, bus.o_odd, w.d, w.id, w.odd);
                end
            end
        end
        if (ev && bus.o_r && sb.size() > 0) begin
            olog.push_back('{cyc, bus.o_d, int'(bus.o_id), bus.o_odd});
            void'(sb.pop_front());
        end
        if (g >= 0) begin
            sb.push_back('{pq[g][0].d0, g, 1'b0});
            sb.push_back('{pq[g][0].d1, g, 1'b1});
            void'(pq[g].pop_front());
        end
        m_phase = 1 - m_phase;
        if (ev && bus.o_r) m_left--;
        if (g >= 0) begin
            m_left = 2;
            m_ptr  = (g + 1) % 4;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int max_cycles);
        int  n;
        bit  busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < max_cycles) begin
            busy = (sb.size() > 0) || (m_left != 0);
            for (int k = 0; k < 4; k++) if (pq[k].size() > 0) busy = 1'b1;
            if (busy) begin
                step();
                n++;
            end
        end
        tests_run++;
        if (busy) begin
            tests_failed++;
            $display("FAIL drain_timeout: got still busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.i_v  = '0;
        bus.i_d0 = '0;
        bus.i_d1 = '0;
        bus.o_r  = 1'b1;
        for (int k = 0; k < 4; k++) pq[k].delete();
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic exp_lo[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        tests_run++;
        if (bus.o_v !== 1'b0 || bus.o_d !== 8'h00 || bus.o_id !== 2'd0 || bus.o_odd !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%0b d=%h id=%0d odd=%0b expected 0,00,0,0",
                     bus.o_v, bus.o_d, bus.o_id, bus.o_odd);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (clk_lo !== exp_lo[i] || bus.o_v !== 1'b0 || bus.i_r !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_idle %0d: got clk_lo=%0b o_v=%0b i_r=%b expected %0b,0,0000",
                         i, clk_lo, bus.o_v, bus.i_r, exp_lo[i]);
            end
            step();
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        pq[1].push_back('{8'h11, 8'h22});
        pq[1].push_back('{8'h33, 8'h44});
        drain(20);
        tests_run++;
        if (olog.size() != 4) begin
            tests_failed++;
            $display("FAIL single_count: got %0d words expected 4", olog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (olog[i].d !== exp_d[i] || olog[i].id != 1 || olog[i].odd !== i[0] ||
                    olog[i].cyc != olog[0].cyc + i) begin
                    tests_failed++;
                    $display("FAIL single_word %0d: got d=%h id=%0d odd=%0b cyc=%0d expected d=%h id=1 odd=%0b cyc=%0d",
                             i, olog[i].d, olog[i].id, olog[i].odd, olog[i].cyc, exp_d[i], i[0], olog[0].cyc + i);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_id[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        do_reset();
        pq[0].push_back('{8'h00, 8'h01});
        pq[0].push_back('{8'h08, 8'h09});
        pq[1].push_back('{8'h02, 8'h03});
        pq[2].push_back('{8'h04, 8'h05});
        pq[3].push_back('{8'h06, 8'h07});
        drain(40);
        tests_run++;
        if (olog.size() != 10) begin
            tests_failed++;
            $display("FAIL rr_count: got %0d words expected 10", olog.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                tests_run++;
                if (olog[i].id != exp_id[i] || olog[i].cyc != olog[0].cyc + i) begin
                    tests_failed++;
                    $display("FAIL rr_word %0d: got id=%0d cyc=%0d expected id=%0d cyc=%0d",
                             i, olog[i].id, olog[i].cyc, exp_id[i], olog[0].cyc + i);
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        pq[2].push_back('{8'hA5, 8'h5A});
        pq[3].push_back('{8'hC3, 8'h3C});
        step();
        step();
        bus.o_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (bus.o_v !== 1'b1 || bus.o_d !== 8'hA5 || bus.o_odd !== 1'b0 || bus.i_r !== 4'b0000) begin
                tests_failed++;
                $display("FAIL stall_hold %0d: got v=%0b d=%h odd=%0b i_r=%b expected 1,a5,0,0000",
                         i, bus.o_v, bus.o_d, bus.o_odd, bus.i_r);
            end
            step();
        end
        bus.o_r = 1'b1;
        step();
        step();
        #1;
        tests_run++;
        if (clk_lo !== 1'b1 || bus.i_r !== 4'b1000 || bus.o_v !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_reload: got clk_lo=%0b i_r=%b o_v=%0b expected 1,1000,0",
                     clk_lo, bus.i_r, bus.o_v);
        end
        drain(20);
        tests_run++;
        if (olog.size() != 4 || olog[0].d !== 8'hA5 || olog[1].d !== 8'h5A ||
            olog[2].d !== 8'hC3 || olog[3].d !== 8'h3C) begin
            tests_failed++;
            $display("FAIL stall_sequence: got %0d words expected a5,5a,c3,3c", olog.size());
        end
    endtask

    task automatic test_bubble();
        do_reset();
        pq[0].push_back('{8'h01, 8'h02});
        pq[1].push_back('{8'h03, 8'h04});
        step();
        step();
        bus.o_r = 1'b0;
        step();
        bus.o_r = 1'b1;
        step();
        step();
        #1;
        tests_run++;
        if (bus.o_v !== 1'b0 || clk_lo !== 1'b1 || bus.i_r !== 4'b0010) begin
            tests_failed++;
            $display("FAIL bubble_idle: got o_v=%0b clk_lo=%0b i_r=%b expected 0,1,0010",
                     bus.o_v, clk_lo, bus.i_r);
        end
        step();
        tests_run++;
        if (bus.o_v !== 1'b1 || bus.o_d !== 8'h03) begin
            tests_failed++;
            $display("FAIL bubble_resume: got o_v=%0b o_d=%h expected 1,03", bus.o_v, bus.o_d);
        end
        drain(20);
        tests_run++;
        if (olog.size() != 4 || olog[2].cyc - olog[1].cyc != 2 || olog[3].cyc - olog[2].cyc != 1) begin
            tests_failed++;
            $display("FAIL bubble_gap: got %0d words expected exactly one idle cycle between pairs", olog.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                pq[k].push_back('{8'(k*16 + j*2), 8'(k*16 + j*2 + 1)});
            end
        end
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus.o_v !== 1'b0 || bus.i_r !== 4'b0000 || clk_lo !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: got o_v=%0b i_r=%b clk_lo=%0b expected 0,0000,0",
                     bus.o_v, bus.i_r, clk_lo);
        end
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        drain(100);
        tests_run++;
        if (olog.size() == 0 || olog[0].id != 0 || olog[0].odd !== 1'b0 || olog[0].d !== 8'h02) begin
            tests_failed++;
            $display("FAIL reset_mid_first: got %0d words, first id=%0d d=%h expected id=0 d=02 odd=0",
                     olog.size(), (olog.size() > 0) ? olog[0].id : -1, (olog.size() > 0) ? olog[0].d : 8'h00);
        end
    endtask

    initial begin
        bus.i_v  = '0;
        bus.i_d0 = '0;
        bus.i_d1 = '0;
        bus.o_r  = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_bubble();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1);
    end
endmodule
